// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud-period derivation,
// used by both the receiver and the companion transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } uart_state_e;

  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int baud_half(input int clk_freq, input int baud);
    return baud_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CNT_MAX-1 while enabled, held at zero otherwise,
// with half-period and full-period terminal-count strobes.
module uart_baud_cnt #(
  parameter int CNT_MAX  = 10,
  parameter int CNT_HALF = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic half_tc_o,
  output logic full_tc_o
);

  localparam int CW = $clog2(CNT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign half_tc_o = run_i && (cnt_q == CW'(CNT_HALF - 1));
  assign full_tc_o = run_i && (cnt_q == CW'(CNT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || clr_i || full_tc_o) cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1-style UART receiver: synchronises rx, detects the start edge, samples
// mid-bit and strobes uart_flag per good frame or frame_err on a low stop bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int D_WIDTH  = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               rx,
  output logic [D_WIDTH-1:0] uart_data,
  output logic               uart_flag,
  output logic               frame_err,
  output logic               rx_busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int BAUD_HALF    = baud_half(CLK_FREQ, BAUD);
  localparam int BCW          = $clog2(D_WIDTH + 1);

  if (BAUD_CNT_MAX < 4) begin : g_baud_check
    $error("uart_rx_frame: CLK_FREQ/BAUD must be at least 4");
  end

  logic               rx_m_q, rx_s_q, rx_d_q;
  logic               fall;
  uart_state_e        state_q;
  logic [BCW-1:0]     bit_cnt_q;
  logic [D_WIDTH-1:0] shift_q;
  logic [D_WIDTH-1:0] data_q;
  logic               flag_q, err_q, busy_q;
  logic               half_tc, full_tc, cnt_run, cnt_clr;

  // Flops preset to the idle level so reset itself never looks like an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign fall    = rx_d_q & ~rx_s_q;
  assign cnt_run = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  // Restart after the half-period so DATA/STOP samples land mid-bit.
  assign cnt_clr = ((state_q == ST_IDLE) && fall) || ((state_q == ST_START) && half_tc);

  uart_baud_cnt #(
    .CNT_MAX  (BAUD_CNT_MAX),
    .CNT_HALF (BAUD_HALF)
  ) u_baud_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run_i     (cnt_run),
    .clr_i     (cnt_clr),
    .half_tc_o (half_tc),
    .full_tc_o (full_tc)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (half_tc) begin
            if (!rx_s_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (full_tc) begin
            shift_q   <= {rx_s_q, shift_q[D_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCW'(D_WIDTH - 1)) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tc) begin
            if (rx_s_q) begin
              data_q  <= shift_q;
              flag_q  <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_HI;
            end
          end
        end
        ST_WAIT_HI: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_data = data_q;
  assign uart_flag = flag_q;
  assign frame_err = err_q;
  assign rx_busy   = busy_q;

endmodule
